// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the async FIFO write port.
// N requesters share one write port. Each grant lasts for at most BURST accepted
// words. The block drives winc (pointer increment and memory write enable) and
// wdata for the write-pointer gray counter and the FIFO memory.
//
// Handshake: req[i] acts as "valid" and is a level. The requester holds req[i]
// and its din slice stable until the word is taken. ack[i] (equal to winc for
// the granted requester) acts as "accept". A word moves on every cycle where
// gnt[i] & req[i] & !wfull holds, and in no other cycle. Dropping req[g] while
// granted ends the grant at the next edge and writes nothing in that cycle.
// The FSM state is visible on busy (GRANT = 1) and on gnt (the owner).
module fifo_wr_arbiter #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    input  logic           wfull,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   gnt,
    output logic           winc,
    output logic [W-1:0]   wdata,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N - 1);

    logic [0:0]    state;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gidx;       // index of the current owner, kept alongside gnt_q
    logic [IW-1:0] rr_ptr;     // highest-priority index for the next arbitration
    logic [CW-1:0] burst_cnt;  // words accepted in the current grant

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  pick_onehot;
    logic [W-1:0]  sel_data;
    logic          req_g;
    logic          in_grant;
    logic          release_c;
    logic [IW-1:0] next_ptr;

    // Pick the first requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int            t;
        logic [IW-1:0] cand;
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        t           = 0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            t = int'(rr_ptr) + k;
            if (t >= N) begin
                t = t - N;
            end
            cand = t[IW-1:0];
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // Route the owner's data slice and request bit.
    always_comb begin
        sel_data = '0;
        req_g    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gidx == IW'(i)) begin
                sel_data = din[i*W +: W];
                req_g    = req[i];
            end
        end
    end

    // Write-side outputs. Reset masks them in the same cycle so a burst that is
    // abandoned by reset writes nothing on the reset edge.
    always_comb begin
        in_grant  = (state == ST_GRANT) && !rst;
        winc      = in_grant && req_g && !wfull;
        ack       = winc ? gnt_q : '0;
        wdata     = in_grant ? sel_data : '0;
        busy      = in_grant;
        gnt       = gnt_q;
        // The grant ends when the owner drops its request, or when the
        // BURST-th word is being accepted.
        release_c = (state == ST_GRANT) &&
                    (!req_g || (winc && (burst_cnt == CNT_LAST)));
        next_ptr  = (gidx == IDX_MAX) ? '0 : gidx + IW'(1);
    end

    // IDLE/GRANT state machine with the round-robin pointer and the burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_q     <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_GRANT;
                        gnt_q     <= pick_onehot;
                        gidx      <= pick_idx;
                        burst_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_c) begin
                        state     <= ST_IDLE;
                        gnt_q     <= '0;
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                    end else if (winc) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. A behavioural model tracks the owner as an
// integer (-1 = idle) and counts accepted words. Expected words enter a
// scoreboard queue, and every output is compared on the falling edge.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din = '0;
    logic           wfull = 1'b0;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           winc;
    logic [W-1:0]   wdata;
    logic           busy;

    fifo_wr_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .wfull (wfull),
        .ack   (ack),
        .gnt   (gnt),
        .winc  (winc),
        .wdata (wdata),
        .busy  (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model
    int m_owner = -1;
    int m_ptr   = 0;
    int m_words = 0;
    logic [N-1:0] e_gnt, e_ack;
    logic         e_winc, e_busy;
    logic [W-1:0] e_wdata;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_w;

    // Expected outputs for the current cycle, computed at the falling edge.
    task automatic sample();
        @(negedge clk);
        e_gnt   = '0;
        e_busy  = 1'b0;
        e_winc  = 1'b0;
        e_wdata = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            if (!rst) begin
                e_busy  = 1'b1;
                e_wdata = din[m_owner*W +: W];
                e_winc  = req[m_owner] && !wfull;
            end
        end
        e_ack = e_winc ? e_gnt : '0;
        if (e_winc) exp_q.push_back(e_wdata);
    endtask

    // Advance the model across the rising edge, then step off it.
    task automatic advance();
        bit found;
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_words = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                    m_words = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_words = 0;
        end else if (e_winc) begin
            m_words++;
            if (m_words == BURST) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_words = 0;
            end
        end
        #1;
    endtask

    // driver tasks
    task automatic drive_din();
        for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; wfull = 1'b0;
        drive_din();
        sample();
        advance();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; wfull = 1'b0;
        drive_din();
        sample();
        advance();
        for (int c = 0; c < 4; c++) begin
            rst = (c < 2);
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL reset c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            total++;
            if ({gnt, ack, winc, wdata, busy} !== '0) begin
                bad++;
                $display("FAIL reset_zero c=%0d got %b want all zero", c, {gnt, ack, winc, wdata, busy});
            end
            advance();
        end
    endtask

    task automatic test_single_burst();
        int nw = 0;
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL single c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            if (winc === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL single_sb c=%0d got wdata=%h want none", c, wdata);
                end else begin
                    sb_w = exp_q.pop_front();
                    if (wdata !== sb_w) begin
                        bad++;
                        $display("FAIL single_sb c=%0d got wdata=%h want %h", c, wdata, sb_w);
                    end
                end
            end
            if (c >= 1 && c <= 4 && winc === 1'b1 && ack === 4'b0100) nw++;
            if (c == 1 || c == 5 || c == 6) begin
                total++;
                if (gnt !== ((c == 5) ? 4'b0000 : 4'b0100)) begin
                    bad++;
                    $display("FAIL single_gnt c=%0d got %b want %b", c, gnt, (c == 5) ? 4'b0000 : 4'b0100);
                end
            end
            advance();
        end
        total++;
        if (nw != 4) begin
            bad++;
            $display("FAIL single_writes got %0d want 4", nw);
        end
    endtask

    task automatic test_round_robin();
        int nw = 0;
        int gi;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] prev = '0;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL rr c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            if (gnt !== '0 && gnt !== prev) begin
                gi = -1;
                for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gi = i;
                order.push_back(gi);
            end
            prev = gnt;
            if (winc === 1'b1) nw++;
            advance();
        end
        total++;
        if (order.size() != 5) begin
            bad++;
            $display("FAIL rr_order_len got %0d want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (order[i] != exp_order[i]) begin
                    bad++;
                    $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
        total++;
        if (nw != 20) begin
            bad++;
            $display("FAIL rr_writes got %0d want 20", nw);
        end
    endtask

    task automatic test_full_stall();
        int nw = 0;
        int last = -1;
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            wfull = (c >= 3 && c <= 5);
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL stall c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            if (c >= 3 && c <= 5) begin
                total++;
                if ({winc, ack, gnt} !== {1'b0, 4'b0000, 4'b0010}) begin
                    bad++;
                    $display("FAIL stall_hold c=%0d got winc=%b ack=%b gnt=%b want 0/0000/0010", c, winc, ack, gnt);
                end
            end
            if (winc === 1'b1) begin
                nw++;
                last = c;
            end
            advance();
        end
        wfull = 1'b0;
        total++;
        if (nw != 4 || last != 7) begin
            bad++;
            $display("FAIL stall_writes got n=%0d last=%0d want n=4 last=7", nw, last);
        end
    endtask

    task automatic test_early_drop();
        int nw = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req = (c <= 2) ? 4'b1000 : ((c == 3) ? 4'b0000 : 4'b1001);
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL drop c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            if (c <= 3 && winc === 1'b1) nw++;
            if (c == 3 || c == 4 || c == 5 || c == 8) begin
                total++;
                if ({winc, gnt} !== ((c == 3) ? {1'b0, 4'b1000} :
                                     (c == 4) ? {1'b0, 4'b0000} : {1'b1, 4'b0001})) begin
                    bad++;
                    $display("FAIL drop_seq c=%0d got winc=%b gnt=%b", c, winc, gnt);
                end
            end
            advance();
        end
        total++;
        if (nw != 2) begin
            bad++;
            $display("FAIL drop_writes got %0d want 2", nw);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req = (c <= 7) ? 4'b0100 : 4'b1100;
            rst = (c == 7);
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL rstmid c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            if (c == 6 || c == 7) begin
                total++;
                if (winc !== (c == 6)) begin
                    bad++;
                    $display("FAIL rstmid_winc c=%0d got %b want %b", c, winc, (c == 6));
                end
            end
            if (c == 8 || c == 9) begin
                total++;
                if (gnt !== ((c == 8) ? 4'b0000 : 4'b0100)) begin
                    bad++;
                    $display("FAIL rstmid_gnt c=%0d got %b want %b", c, gnt, (c == 8) ? 4'b0000 : 4'b0100);
                end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            wfull = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            drive_din();
            sample();
            total++;
            if ({gnt, ack, winc, wdata, busy} !== {e_gnt, e_ack, e_winc, e_wdata, e_busy}) begin
                bad++;
                $display("FAIL random c=%0d got gnt=%b ack=%b winc=%b wdata=%h busy=%b want gnt=%b ack=%b winc=%b wdata=%h busy=%b",
                         c, gnt, ack, winc, wdata, busy, e_gnt, e_ack, e_winc, e_wdata, e_busy);
            end
            if (winc === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL random_sb c=%0d got wdata=%h want none", c, wdata);
                end else begin
                    sb_w = exp_q.pop_front();
                    if (wdata !== sb_w) begin
                        bad++;
                        $display("FAIL random_sb c=%0d got wdata=%h want %h", c, wdata, sb_w);
                    end
                end
            end
            advance();
        end
        rst = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_sb_left got %0d words want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_early_drop();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
